reg_file: RTL and testbench
===========================

# reg_file

General-purpose register file of the MIPS datapath: 32 registers of 32 bits, two combinational read ports for the decode stage, one synchronous write port for write-back. Register 0 is hardwired to zero. A same-cycle write is forwarded to the read ports, so an instruction reading a register that write-back is updating in the same cycle receives the new value.

## Interface
- No parameters: 32 entries × 32 bits, fixed.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- addr1  input  5  read port 1 register index.
- addr2  input  5  read port 2 register index.
- addr3  input  5  write port register index.
- din  input  32  write data.
- regWrite  input  1  write enable for the write port.
- dout1  output  32  read data for addr1.
- dout2  output  32  read data for addr2.

## Operation
- Storage: registers r1..r31, 32 bits each. r0 has no storage; it always reads 0.
- Write: on a rising clk edge with rst=0 and regWrite=1, r[addr3] ← din.
  - addr3=0 writes are discarded.
  - regWrite=0: no state change.
- Reset: on a rising clk edge with rst=1, r1..r31 ← 0x0000_0000. rst takes priority over a concurrent write.
- Reads are purely combinational from addr1/addr2, the registers, and the forwarding path:
  - addrN=0: doutN = 0x0000_0000, even if addr3=0 with regWrite=1.
  - regWrite=1, addr3=addrN≠0, rst=0: doutN = din (write-through bypass).
  - Otherwise doutN = r[addrN].
- Both read ports are independent. Both may address the same register, and both may match the write address in the same cycle.
- X/undriven addresses: no requirement on read data, but state is never corrupted unless regWrite=1.

## Timing
- Read latency: zero cycles; doutN settles combinationally after addrN, din, regWrite or register contents change.
- Write latency: the value is stored at the first rising edge where the write conditions hold. The bypass makes it visible on the read ports in the same cycle.
- Reset latency: one rising edge with rst=1 clears all registers. While rst=1, reads return the pre-reset contents until that edge, then 0. The bypass is suppressed while rst=1.
- Reset mid-operation: a write presented in the same cycle as rst=1 is lost.
- Outputs after reset: dout1 = dout2 = 0x0000_0000 for any address, provided regWrite=0.
- There is no handshake. Writes complete unconditionally, so back-to-back writes on consecutive cycles are supported, including repeated writes to the same address (last one wins).

## Test plan
- Reset, then read sweep: rst=1 for ≥1 edge, then regWrite=0 and addr1/addr2 swept over 0..31 -> every read returns 0x0000_0000.
- r0 protection: write addr3=0, din=0x1234_5678, regWrite=1; then addr1=0 -> dout1=0x0000_0000, both during and after the write cycle.
- Basic write/read: write addr3=1, din=0x1111_1111; next cycle regWrite=0, addr1=0, addr2=1 -> dout1=0x0000_0000, dout2=0x1111_1111.
- Same-cycle bypass: addr1=2, addr3=2, din=0x2222_2222, regWrite=1 -> dout1=0x2222_2222 before the edge and after it. Repeat with addr2=2 -> dout2=0x2222_2222.
- Write disable and overwrite:
  - Write r5=0xAAAA_5555.
  - Then regWrite=0 with addr3=5, din=0xFFFF_FFFF -> r5 still reads 0xAAAA_5555.
  - Then consecutive writes r5=0x1, r5=0x2 -> r5 reads 0x0000_0002.
- Reset priority: fill r1..r31 with their index; assert rst=1 together with regWrite=1, addr3=7, din=0xDEAD_BEEF -> after the edge, r7 and all other registers read 0x0000_0000.

Source files
------------

// File: rtl/reg_file_if.sv
// Decode/write-back side bundle of the register file: two read ports and one write port.
// There is no handshake: reads are combinational and a write with regWrite=1 always completes.
interface reg_file_if;
  logic [4:0]  addr1;
  logic [4:0]  addr2;
  logic [4:0]  addr3;
  logic [31:0] din;
  logic        regWrite;
  logic [31:0] dout1;
  logic [31:0] dout2;

  modport master (
    output addr1, addr2, addr3, din, regWrite,
    input  dout1, dout2
  );

  modport slave (
    input  addr1, addr2, addr3, din, regWrite,
    output dout1, dout2
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 MIPS register file: r0 reads zero, two combinational read ports,
// one synchronous write port with same-cycle write-through to the read ports.
module reg_file (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  // Entry 0 is never written, so it stays at its reset value and is masked on read anyway.
  logic [31:0] regs [0:31];
  logic        wr_en;
  logic        fwd_en;

  assign wr_en  = bus.regWrite && (bus.addr3 != 5'd0);
  // Forwarding is off during reset so reads show the pre-reset contents until the edge.
  assign fwd_en = wr_en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (wr_en) begin
      regs[bus.addr3] <= bus.din;
    end
  end

  always_comb begin
    bus.dout1 = regs[bus.addr1];
    if (bus.addr1 == 5'd0) begin
      bus.dout1 = 32'h0000_0000;
    end else if (fwd_en && (bus.addr3 == bus.addr1)) begin
      bus.dout1 = bus.din;
    end
  end

  always_comb begin
    bus.dout2 = regs[bus.addr2];
    if (bus.addr2 == 5'd0) begin
      bus.dout2 = 32'h0000_0000;
    end else if (fwd_en && (bus.addr3 == bus.addr2)) begin
      bus.dout2 = bus.din;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: the driver pushes hand-computed read values per cycle,
// a negedge monitor pops and compares them against dout1/dout2.
module tb_reg_file;

  logic clk;
  logic rst;
  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {dout1, dout2} expected for the cycle just driven
  logic [63:0] exp_q[$];
  string       name_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk_cnt++;
      if ({bus.dout1, bus.dout2} === e) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: dout1=%h dout2=%h expected dout1=%h dout2=%h",
                 n, bus.dout1, bus.dout2, e[63:32], e[31:0]);
      end
    end
  end

  // Driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [31:0] d, input logic we, input logic r);
    @(posedge clk);
    #1;
    bus.addr1    = a1;
    bus.addr2    = a2;
    bus.addr3    = a3;
    bus.din      = d;
    bus.regWrite = we;
    rst          = r;
  endtask

  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                      input logic [31:0] d, input logic we, input logic r,
                      input logic [31:0] e1, input logic [31:0] e2, input string n);
    drive(a1, a2, a3, d, we, r);
    exp_q.push_back({e1, e2});
    name_q.push_back(n);
  endtask

  initial begin
    bus.addr1    = 5'd0;
    bus.addr2    = 5'd0;
    bus.addr3    = 5'd0;
    bus.din      = 32'h0;
    bus.regWrite = 1'b0;
    rst          = 1'b1;

    // Reset, storage contents unknown before the first edge
    drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);

    // Read sweep after reset
    for (int i = 0; i < 32; i++) begin
      step(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_sweep");
    end

    // r0 protection
    step(5'd0, 5'd0, 5'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 32'h0, "r0_during_write");
    step(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "r0_after_write");

    // Basic write/read
    step(5'd0, 5'd1, 5'd1, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 32'h1111_1111, "w1_bypass");
    step(5'd0, 5'd1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1111_1111, "w1_read");

    // Same-cycle bypass on each port, then both ports at once
    step(5'd2, 5'd1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, 32'h2222_2222, 32'h1111_1111, "bypass1_before");
    step(5'd2, 5'd1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h2222_2222, 32'h1111_1111, "bypass1_after");
    step(5'd0, 5'd2, 5'd2, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 32'h3333_3333, "bypass2_before");
    step(5'd2, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'h3333_3333, 32'h3333_3333, "bypass2_after");
    step(5'd2, 5'd2, 5'd2, 32'h4444_4444, 1'b1, 1'b0, 32'h4444_4444, 32'h4444_4444, "bypass_both");

    // Write disable and overwrite
    step(5'd5, 5'd0, 5'd5, 32'hAAAA_5555, 1'b1, 1'b0, 32'hAAAA_5555, 32'h0, "r5_write");
    step(5'd5, 5'd5, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555, "we0_no_bypass");
    step(5'd5, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0, 32'hAAAA_5555, 32'h4444_4444, "we0_kept");
    step(5'd5, 5'd0, 5'd5, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 32'h0, "r5_w1");
    step(5'd5, 5'd0, 5'd5, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0002, 32'h0, "r5_w2");
    step(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0000_0002, 32'h0000_0002, "last_wins");

    // Fill r1..r31 with their index and read back
    for (int i = 1; i < 32; i++) begin
      step(5'(i), 5'd0, 5'(i), 32'(i), 1'b1, 1'b0, 32'(i), 32'h0, "fill_bypass");
    end
    for (int i = 0; i < 32; i++) begin
      step(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0, 32'(i), 32'(31 - i), "fill_read");
    end

    // Reset beats a concurrent write; no bypass while rst=1
    step(5'd7, 5'd9, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'd7, 32'd9, "rst_pre_edge");
    for (int i = 0; i < 32; i++) begin
      step(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "post_rst_sweep");
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
